cpu_top: RTL and testbench
==========================

CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 SHALL have no parameters; reset PC fixed at 0x00000000.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_mem_addr  output  32  byte address of the instruction being fetched; equals PC, combinational from the PC register.
REQ-005 i_mem_rdata  input  32  instruction word at i_mem_addr, valid in the same cycle (combinational memory).
REQ-006 d_mem_addr  output  32  byte address of the load/store in the MEM stage.
REQ-007 d_mem_wdata  output  32  store data, lane-replicated.
REQ-008 d_mem_wen  output  4  byte write enables; memory writes lanes at the next rising edge; 0000 = no write.
REQ-009 d_mem_rdata  input  32  word at d_mem_addr[31:2], valid in the same cycle.

Function
REQ-010 SHALL implement RV32I user ISA: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP arithmetic, logical and shift instructions.
REQ-011 FENCE, ECALL, EBREAK, SYSTEM/CSR and unknown opcodes SHALL execute as NOP: no register write, no memory write, PC+4.
REQ-012 SHALL be a 5-stage in-order pipeline (IF, ID, EX, MEM, WB) issuing at most one instruction per cycle.
REQ-013 Register file: 32x32; x0 reads 0 and ignores writes; two combinational reads in ID, one write in WB.
REQ-014 A WB write to a register read in ID in the same cycle SHALL be bypassed to ID.
REQ-015 EX operands SHALL forward from MEM (ALU result) with priority over WB (ALU or load result); never forward x0.
REQ-016 Load followed immediately by a dependent instruction: 1-cycle stall; PC and IF/ID hold; bubble into EX.
REQ-017 Branches and jumps SHALL resolve in EX; on taken branch, JAL or JALR, IF and ID are flushed (2-cycle penalty) and PC loads the target.
REQ-018 JALR target = (rs1 + imm) with bit 0 cleared; JAL/JALR write PC+4 to rd.
REQ-019 Branch compare: signed for BLT/BGE, unsigned for BLTU/BGEU; target = branch PC + B-immediate.
REQ-020 Shift amount = low 5 bits of rs2/immediate; SRA/SRAI sign-fill; SLT/SLTU produce 0 or 1.
REQ-021 All arithmetic is 32-bit wrap-around; overflow is ignored.
REQ-022 Store byte lanes:
- SB: wen = 0001 << addr[1:0], wdata = byte x4.
- SH: wen = 0011 << (2*addr[1]), wdata = halfword x2.
- SW: wen = 1111.
REQ-023 Loads SHALL select the byte/halfword lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 Misaligned addresses: low bits are used only for lane selection; no trap.
REQ-025 d_mem_wen SHALL be 0000 in any cycle without a valid store in MEM, including bubbles and flushed slots.
REQ-026 Latency: an ALU result is written in WB 4 cycles after its fetch cycle and is usable by the next instruction with no stall via forwarding.

Reset
REQ-027 While rst=1 at a rising edge:
- PC <= 0.
- All pipeline registers become bubbles; d_mem_wen = 0000 from that edge.
- All 32 registers <= 0.
REQ-028 The first instruction fetched after rst deasserts is at address 0x00000000.
REQ-029 Reset asserted mid-program SHALL abort in-flight instructions with no further register or memory writes.

Verification
REQ-030 ADDI x1,x0,5; ADDI x2,x1,7 (back-to-back) -> x2=12, no stall.
REQ-031 Loop: x6 accumulates 10,20,...,50 via BNE/BEQ/BLT/BGE/BLTU/BGEU mix, with not-taken paths adding 0 -> final x6=140; each flushed instruction leaves no register write.
REQ-032 SW x5=0x11223344 to 0x100; LB from 0x101 -> 0x00000033; LH from 0x102 -> 0x00001122; SB 0xAB to 0x103 -> wen=1000, word=0xAB223344.
REQ-033 LW x3 then ADD x4,x3,x3 -> exactly 1 stall cycle, x4 = 2*mem.
REQ-034 JAL x1,+8 at 0x10 -> x1=0x14, next executed instruction at 0x18; JALR x0,0(x1) -> PC=0x14.
REQ-035 rst asserted mid-loop for 1 cycle -> registers all 0, i_mem_addr=0 next cycle, d_mem_wen=0000.

Source files
------------

// File: rtl/cpu_top.sv
// cpu_top: five-stage in-order RV32I integer pipeline (IF, ID, EX, MEM, WB).
// Forwarding from MEM/WB, one-cycle load-use stall, and branches/jumps resolved in EX.
module cpu_top (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] d_mem_addr,
    output logic [31:0] d_mem_wdata,
    output logic [3:0]  d_mem_wen,
    input  logic [31:0] d_mem_rdata
);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       a_is_pc;
        logic       a_is_zero;
        logic       b_is_imm;
        alu_op_e    alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Pipeline state
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;

    ctrl_t       id_ex_ctrl;
    logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;

    logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
    logic [2:0]  ex_mem_funct3;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_result, ex_mem_store_data;

    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_result;

    logic [31:0] rf [32];

    assign i_mem_addr = pc;

    // ---------------- ID ----------------
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    ctrl_t       id_ctrl;
    logic [31:0] id_imm, id_rs1_val, id_rs2_val;
    logic        uses_rs1, uses_rs2, wb_we, stall;

    assign opcode = if_id_instr[6:0];
    assign rd     = if_id_instr[11:7];
    assign f3     = if_id_instr[14:12];
    assign rs1    = if_id_instr[19:15];
    assign rs2    = if_id_instr[24:20];

    always_comb begin
        // NOTE: every output is given a default first so no path through the case can infer a latch.
        id_ctrl        = '0;
        id_ctrl.funct3 = f3;
        id_imm         = '0;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        case (opcode)
            OP_LUI: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.a_is_zero = 1'b1; id_ctrl.b_is_imm = 1'b1;
                id_imm = {if_id_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.a_is_pc = 1'b1; id_ctrl.b_is_imm = 1'b1;
                id_imm = {if_id_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.jal = 1'b1;
                id_imm = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                          if_id_instr[20], if_id_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.jalr = 1'b1; uses_rs1 = 1'b1;
                id_imm = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
            end
            OP_BRANCH: begin
                id_ctrl.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                id_imm = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                          if_id_instr[30:25], if_id_instr[11:8], 1'b0};
            end
            OP_LOAD: begin
                id_ctrl.reg_write = 1'b1; id_ctrl.mem_read = 1'b1; id_ctrl.b_is_imm = 1'b1;
                uses_rs1 = 1'b1;
                id_imm = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
            end
            OP_STORE: begin
                id_ctrl.mem_write = 1'b1; id_ctrl.b_is_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                id_imm = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
            end
            OP_IMM: begin
                // Only SRAI uses bit 30 as a selector; in other immediates it is data.
                id_ctrl.reg_write = 1'b1; id_ctrl.b_is_imm = 1'b1; uses_rs1 = 1'b1;
                id_ctrl.alu_op = alu_decode(f3, if_id_instr[30] && (f3 == 3'b101));
                id_imm = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
            end
            OP_OP: begin
                id_ctrl.reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                id_ctrl.alu_op = alu_decode(f3, if_id_instr[30]);
            end
            default: ;
        endcase
        if (!if_id_valid) begin
            id_ctrl  = '0;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

    // Register reads with same-cycle WB bypass
    assign wb_we      = mem_wb_reg_write && (mem_wb_rd != 5'd0);
    assign id_rs1_val = (rs1 == 5'd0) ? 32'd0 : (wb_we && mem_wb_rd == rs1) ? mem_wb_result : rf[rs1];
    assign id_rs2_val = (rs2 == 5'd0) ? 32'd0 : (wb_we && mem_wb_rd == rs2) ? mem_wb_result : rf[rs2];

    assign stall = id_ex_ctrl.mem_read && (id_ex_rd != 5'd0) &&
                   ((uses_rs1 && rs1 == id_ex_rd) || (uses_rs2 && rs2 == id_ex_rd));

    // ---------------- EX ----------------
    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_out, ex_result, target, jalr_sum;
    logic        br_cond, taken;

    always_comb begin
        fwd_a = id_ex_rs1_val;
        if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs1)
            fwd_a = ex_mem_result;
        else if (wb_we && mem_wb_rd == id_ex_rs1)
            fwd_a = mem_wb_result;

        fwd_b = id_ex_rs2_val;
        if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs2)
            fwd_b = ex_mem_result;
        else if (wb_we && mem_wb_rd == id_ex_rs2)
            fwd_b = mem_wb_result;

        op_a = id_ex_ctrl.a_is_zero ? 32'd0 : id_ex_ctrl.a_is_pc ? id_ex_pc : fwd_a;
        op_b = id_ex_ctrl.b_is_imm ? id_ex_imm : fwd_b;

        case (id_ex_ctrl.alu_op)
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_SLL:  alu_out = op_a << op_b[4:0];
            ALU_SLT:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_out = {31'd0, op_a < op_b};
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SRL:  alu_out = op_a >> op_b[4:0];
            ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:   alu_out = op_a | op_b;
            ALU_AND:  alu_out = op_a & op_b;
            default:  alu_out = op_a + op_b;
        endcase

        case (id_ex_ctrl.funct3)
            3'b000:  br_cond = (fwd_a == fwd_b);
            3'b001:  br_cond = (fwd_a != fwd_b);
            3'b100:  br_cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_cond = (fwd_a <  fwd_b);
            3'b111:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase

        taken     = id_ex_ctrl.jal || id_ex_ctrl.jalr || (id_ex_ctrl.branch && br_cond);
        jalr_sum  = fwd_a + id_ex_imm;
        target    = id_ex_ctrl.jalr ? {jalr_sum[31:1], 1'b0} : id_ex_pc + id_ex_imm;
        ex_result = (id_ex_ctrl.jal || id_ex_ctrl.jalr) ? id_ex_pc + 32'd4 : alu_out;
    end

    // ---------------- MEM ----------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val, mem_result;

    assign d_mem_addr = ex_mem_result;

    always_comb begin
        case (ex_mem_funct3[1:0])
            2'b00:   d_mem_wdata = {4{ex_mem_store_data[7:0]}};
            2'b01:   d_mem_wdata = {2{ex_mem_store_data[15:0]}};
            default: d_mem_wdata = ex_mem_store_data;
        endcase

        d_mem_wen = 4'b0000;
        if (ex_mem_mem_write) begin
            case (ex_mem_funct3[1:0])
                2'b00:   d_mem_wen = 4'b0001 << ex_mem_result[1:0];
                2'b01:   d_mem_wen = ex_mem_result[1] ? 4'b1100 : 4'b0011;
                default: d_mem_wen = 4'b1111;
            endcase
        end

        case (ex_mem_result[1:0])
            2'b00:   ld_byte = d_mem_rdata[7:0];
            2'b01:   ld_byte = d_mem_rdata[15:8];
            2'b10:   ld_byte = d_mem_rdata[23:16];
            default: ld_byte = d_mem_rdata[31:24];
        endcase
        ld_half = ex_mem_result[1] ? d_mem_rdata[31:16] : d_mem_rdata[15:0];

        case (ex_mem_funct3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = d_mem_rdata;
        endcase
        mem_result = ex_mem_mem_read ? load_val : ex_mem_result;
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc                <= 32'd0;
            if_id_valid       <= 1'b0;
            if_id_pc          <= 32'd0;
            if_id_instr       <= 32'd0;
            id_ex_ctrl        <= '0;
            id_ex_pc          <= 32'd0;
            id_ex_rs1_val     <= 32'd0;
            id_ex_rs2_val     <= 32'd0;
            id_ex_imm         <= 32'd0;
            id_ex_rs1         <= 5'd0;
            id_ex_rs2         <= 5'd0;
            id_ex_rd          <= 5'd0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_funct3     <= 3'd0;
            ex_mem_rd         <= 5'd0;
            ex_mem_result     <= 32'd0;
            ex_mem_store_data <= 32'd0;
            mem_wb_reg_write  <= 1'b0;
            mem_wb_rd         <= 5'd0;
            mem_wb_result     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample its predecessor's pre-edge value.
            if (taken) begin
                pc          <= target;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                pc          <= pc + 32'd4;
                if_id_valid <= 1'b1;
                if_id_pc    <= pc;
                if_id_instr <= i_mem_rdata;
            end

            id_ex_ctrl    <= (taken || stall) ? ctrl_t'('0) : id_ctrl;
            id_ex_pc      <= if_id_pc;
            id_ex_rs1_val <= id_rs1_val;
            id_ex_rs2_val <= id_rs2_val;
            id_ex_imm     <= id_imm;
            id_ex_rs1     <= rs1;
            id_ex_rs2     <= rs2;
            id_ex_rd      <= rd;

            ex_mem_reg_write  <= id_ex_ctrl.reg_write;
            ex_mem_mem_read   <= id_ex_ctrl.mem_read;
            ex_mem_mem_write  <= id_ex_ctrl.mem_write;
            ex_mem_funct3     <= id_ex_ctrl.funct3;
            ex_mem_rd         <= id_ex_rd;
            ex_mem_result     <= ex_result;
            ex_mem_store_data <= fwd_b;

            mem_wb_reg_write <= ex_mem_reg_write;
            mem_wb_rd        <= ex_mem_rd;
            mem_wb_result    <= mem_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: unlike a plain RAM, the register file is cleared so all registers read 0 after reset.
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wb_we) begin
            rf[mem_wb_rd] <= mem_wb_result;
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// Directed-vector bench for cpu_top: small programs in a bench-side instruction/data
// memory, with hand-computed register, store and fetch-address expectations.
module tb_cpu_top;

    logic        clk;
    logic        rst;
    logic [31:0] i_mem_addr, i_mem_rdata;
    logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
    logic [3:0]  d_mem_wen;

    cpu_top dut (
        .clk         (clk),
        .rst         (rst),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_wen   (d_mem_wen),
        .d_mem_rdata (d_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic [31:0] trace [128];
    logic [3:0]  st_wen  [8];
    logic [31:0] st_data [8];
    logic [31:0] st_addr [8];
    int          n_st;
    int          cyc;
    int          n_vec;
    int          n_err;

    assign i_mem_rdata = (i_mem_addr[31:10] == 22'd0) ? imem[i_mem_addr[9:2]] : 32'h0000_0013;
    assign d_mem_rdata = (d_mem_addr[31:10] == 22'd0) ? dmem[d_mem_addr[9:2]] : 32'd0;

    // Data memory: cleared while in reset, byte-lane writes otherwise, store log kept.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
            n_st <= 0;
        end else if (d_mem_wen != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (d_mem_wen[b]) dmem[d_mem_addr[9:2]][8*b +: 8] <= d_mem_wdata[8*b +: 8];
            if (n_st < 8) begin
                st_wen[n_st]  <= d_mem_wen;
                st_data[n_st] <= d_mem_wdata;
                st_addr[n_st] <= d_mem_addr;
            end
            n_st <= n_st + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        logic [11:0] v;
        v = 12'(imm);
        return {v, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input int imm);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], rs2, rs1, f3, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input int off);
        logic [11:0] v;  // v[k] = offset bit k+1
        v = 12'(off >>> 1);
        return {v[11], v[9:4], rs2, rs1, f3, v[3:0], v[10], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input int off);
        logic [19:0] u;  // u[k] = offset bit k+1
        u = 20'(off >>> 1);
        return {u[19], u[9:0], u[10], u[18:11], rd, 7'b1101111};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = addi(0, 0, 0);
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        imem[addr >> 2] = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 128) trace[cyc] = i_mem_addr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        trace[0] = i_mem_addr;
    endtask

    task automatic load_branch_prog();
        clear_prog();
        put(32'h00, addi(7, 0, 0));
        put(32'h04, addi(8, 0, 50));
        put(32'h08, addi(9, 0, 10));
        put(32'h0C, addi(6, 0, 0));
        put(32'h10, addi(7, 7, 10));
        put(32'h14, enc_b(3'b000, 7, 9, 12));     // BEQ  i==10 -> skip add
        put(32'h18, enc_r(7'b0, 3'b000, 6, 6, 7)); // ADD  x6 += i
        put(32'h1C, enc_b(3'b001, 0, 0, 8));      // BNE  never
        put(32'h20, enc_b(3'b100, 7, 8, -16));    // BLT  loop
        put(32'h24, enc_b(3'b101, 7, 8, 8));      // BGE  exit, skip 0x28
        put(32'h28, addi(6, 6, 1000));
        put(32'h2C, enc_b(3'b110, 6, 7, 8));      // BLTU not taken
        put(32'h30, enc_b(3'b111, 6, 7, 8));      // BGEU taken, skip 0x34
        put(32'h34, addi(6, 6, 1));
        put(32'h38, addi(11, 0, -1));
        put(32'h3C, enc_b(3'b100, 11, 0, 8));     // BLT  -1<0 signed: taken
        put(32'h40, addi(12, 0, 7));
        put(32'h44, enc_b(3'b110, 11, 0, 8));     // BLTU 0xFFFFFFFF<0: not taken
        put(32'h48, addi(13, 0, 9));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;

        // ---- Dependent ADDIs, latency, reset state ----
        clear_prog();
        put(32'h00, addi(1, 0, 5));
        put(32'h04, addi(2, 1, 7));
        do_reset();
        check("reset_pc", i_mem_addr, 32'h0);
        check("reset_wen", {28'd0, d_mem_wen}, 32'h0);
        check("reset_x5", dut.rf[5], 32'h0);
        repeat (4) tick();
        check("x1_before_wb", dut.rf[1], 32'h0);
        tick();
        check("x1_addi", dut.rf[1], 32'd5);
        tick();
        check("x2_fwd", dut.rf[2], 32'd12);
        check("no_stall_pc3", trace[3], 32'h0C);

        // ---- Stores, loads, lane handling, load-use stall ----
        clear_prog();
        put(32'h00, enc_u(7'b0110111, 5, 20'h11223));
        put(32'h04, addi(5, 5, 'h344));
        put(32'h08, enc_s(3'b010, 0, 5, 'h100));              // SW
        put(32'h0C, enc_i(7'b0000011, 3'b000, 7, 0, 'h101));  // LB
        put(32'h10, enc_i(7'b0000011, 3'b001, 8, 0, 'h102));  // LH
        put(32'h14, addi(9, 0, 'hAB));
        put(32'h18, enc_s(3'b000, 0, 9, 'h103));              // SB
        put(32'h1C, enc_i(7'b0000011, 3'b010, 3, 0, 'h100));  // LW
        put(32'h20, enc_r(7'b0, 3'b000, 4, 3, 3));            // ADD dependent on load
        put(32'h24, enc_i(7'b0000011, 3'b000, 10, 0, 'h103)); // LB
        put(32'h28, enc_i(7'b0000011, 3'b100, 11, 0, 'h103)); // LBU
        put(32'h2C, enc_i(7'b0000011, 3'b101, 12, 0, 'h102)); // LHU
        put(32'h30, enc_i(7'b0000011, 3'b001, 13, 0, 'h102)); // LH
        put(32'h34, enc_s(3'b001, 0, 5, 'h106));              // SH
        do_reset();
        repeat (30) tick();
        check("x5_lui_addi", dut.rf[5], 32'h1122_3344);
        check("lb_0x101", dut.rf[7], 32'h0000_0033);
        check("lh_0x102", dut.rf[8], 32'h0000_1122);
        check("lw_after_sb", dut.rf[3], 32'hAB22_3344);
        check("add_load_use", dut.rf[4], 32'h5644_6688);
        check("lb_sext", dut.rf[10], 32'hFFFF_FFAB);
        check("lbu_zext", dut.rf[11], 32'h0000_00AB);
        check("lhu_zext", dut.rf[12], 32'h0000_AB22);
        check("lh_sext", dut.rf[13], 32'hFFFF_AB22);
        check("store_count", n_st, 32'd3);
        check("sw_wen", {28'd0, st_wen[0]}, 32'hF);
        check("sb_wen", {28'd0, st_wen[1]}, 32'h8);
        check("sb_addr", st_addr[1], 32'h0000_0103);
        check("sb_wdata", st_data[1], 32'hABAB_ABAB);
        check("sh_wen", {28'd0, st_wen[2]}, 32'hC);
        check("sh_wdata", st_data[2], 32'h3344_3344);
        check("mem_0x100", dmem[64], 32'hAB22_3344);
        check("mem_0x104", dmem[65], 32'h3344_0000);
        check("stall_hold_pc", trace[10], 32'h24);
        check("stall_one_cycle", trace[11], 32'h28);

        // ---- JAL / JALR ----
        clear_prog();
        put(32'h00, addi(2, 0, 1));
        put(32'h10, enc_j(1, 8));                             // JAL x1,+8
        put(32'h14, addi(3, 0, 3));
        put(32'h18, addi(4, 4, 1));
        put(32'h1C, enc_b(3'b001, 3, 0, 8));                  // BNE x3,x0 -> 0x24
        put(32'h20, enc_i(7'b1100111, 3'b000, 0, 1, 0));      // JALR x0,0(x1)
        put(32'h24, addi(5, 5, 5));
        do_reset();
        repeat (30) tick();
        check("jal_link", dut.rf[1], 32'h14);
        check("jal_target_pc", trace[7], 32'h18);
        check("jalr_target_pc", trace[12], 32'h14);
        check("jal_flush_x3", dut.rf[3], 32'd3);
        check("visit_count_x4", dut.rf[4], 32'd2);
        check("after_jalr_x5", dut.rf[5], 32'd5);
        check("x2_filler", dut.rf[2], 32'd1);

        // ---- Branch loop ----
        load_branch_prog();
        do_reset();
        repeat (100) tick();
        check("loop_x6", dut.rf[6], 32'd140);
        check("loop_x7", dut.rf[7], 32'd50);
        check("x11_neg", dut.rf[11], 32'hFFFF_FFFF);
        check("blt_signed_skip", dut.rf[12], 32'd0);
        check("bltu_not_taken", dut.rf[13], 32'd9);

        // ---- Reset mid-loop ----
        load_branch_prog();
        do_reset();
        repeat (20) tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) check($sformatf("midrst_x%0d", i), dut.rf[i], 32'd0);
        check("midrst_pc", i_mem_addr, 32'h0);
        check("midrst_wen", {28'd0, d_mem_wen}, 32'h0);
        rst = 1'b0;
        cyc = 0;
        repeat (100) tick();
        check("rerun_x6", dut.rf[6], 32'd140);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
